mem_bus_arbiter: RTL and testbench

Shares the single-port external 16-bit SRAM between instruction fetch (IF) and the memory stage (ME) of the pipeline. Each accepted request becomes a multi-cycle SRAM read or write. The block returns read data with a one-cycle ready pulse and generates per-port stall signals until that pulse. The ME stage result selector consumes `meReadData` when the ME control is a read (2'b10).

---
 rtl/mem_bus_arbiter_if.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: the IF and ME pipeline request/response
// handshakes plus the external single-port SRAM pins.
// The slave modport is the arbiter's view. The master modport is the
// pipeline/SRAM-side view.
interface mem_bus_arbiter_if;
  // Instruction fetch port
  logic        ifReq;
  logic [15:0] ifAddr;
  logic        ifReady;
  logic [15:0] ifData;
  logic        ifStall;

  // Memory stage port
  logic [1:0]  meMemControl;
  logic [15:0] meAddr;
  logic [15:0] meWriteData;
  logic        meReady;
  logic [15:0] meReadData;
  logic        meStall;

  // External SRAM
  logic [15:0] ramAddr;
  logic [15:0] ramDataOut;
  logic        ramDataDrive;
  logic [15:0] ramDataIn;
  logic        ramCE_n;
  logic        ramOE_n;
  logic        ramWE_n;

  modport slave (
    input  ifReq, ifAddr, meMemControl, meAddr, meWriteData, ramDataIn,
    output ifReady, ifData, ifStall, meReady, meReadData, meStall,
           ramAddr, ramDataOut, ramDataDrive, ramCE_n, ramOE_n, ramWE_n
  );

  modport master (
    output ifReq, ifAddr, meMemControl, meAddr, meWriteData, ramDataIn,
    input  ifReady, ifData, ifStall, meReady, meReadData, meStall,
           ramAddr, ramDataOut, ramDataDrive, ramCE_n, ramOE_n, ramWE_n
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port 16-bit SRAM between instruction
// fetch (IF) and the memory stage (ME).
// Each grant runs a fixed-length read or write with registered strobes. The
// arbiter then returns a one-cycle ready pulse to the requester.
// When both ports contend, priority alternates using lastGrantMe.
module mem_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR      = 3'd2,
    WR_HOLD = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        lastGrantMe;
  logic        grantMe;

  logic        ifReadyR;
  logic        meReadyR;
  logic [15:0] ifDataR;
  logic [15:0] meReadDataR;
  logic [15:0] ramAddrR;
  logic [15:0] ramDataOutR;
  logic        ramDataDriveR;
  logic        ramCE_nR;
  logic        ramOE_nR;
  logic        ramWE_nR;

  logic        meActive;
  logic        meWrite;
  logic        anyReq;
  logic        pickMe;
  logic        pickWrite;

  // Decode the ME control field and choose the winner of the next grant
  always_comb begin
    meActive  = 1'b0;
    meWrite   = 1'b0;
    pickMe    = 1'b0;
    case (bus.meMemControl)
      2'b10: begin
        meActive = 1'b1;
        meWrite  = 1'b0;
      end
      2'b01: begin
        meActive = 1'b1;
        meWrite  = 1'b1;
      end
      default: begin
        meActive = 1'b0;   // 2'b00 idle, 2'b11 reserved: no access
        meWrite  = 1'b0;
      end
    endcase
    anyReq = meActive | bus.ifReq;
    if (meActive && bus.ifReq) begin
      pickMe = ~lastGrantMe;   // alternate under contention
    end else if (meActive) begin
      pickMe = 1'b1;
    end else begin
      pickMe = 1'b0;
    end
    pickWrite = pickMe & meWrite;
  end

  // Access sequencer: arbitration, SRAM strobe timing, read capture and ready pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      lastGrantMe   <= 1'b0;
      grantMe       <= 1'b0;
      ifReadyR      <= 1'b0;
      meReadyR      <= 1'b0;
      ifDataR       <= 16'h0000;
      meReadDataR   <= 16'h0000;
      ramAddrR      <= 16'h0000;
      ramDataOutR   <= 16'h0000;
      ramDataDriveR <= 1'b0;
      ramCE_nR      <= 1'b1;
      ramOE_nR      <= 1'b1;
      ramWE_nR      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ifReadyR <= 1'b0;
          meReadyR <= 1'b0;
          if (anyReq) begin
            lastGrantMe <= pickMe;
            grantMe     <= pickMe;
            cnt         <= CNT_LOAD;
            ramCE_nR    <= 1'b0;
            if (pickMe) begin
              ramAddrR    <= bus.meAddr;
              ramDataOutR <= bus.meWriteData;
            end else begin
              ramAddrR    <= bus.ifAddr;
            end
            if (pickWrite) begin
              state         <= WR;
              ramWE_nR      <= 1'b0;
              ramOE_nR      <= 1'b1;
              ramDataDriveR <= 1'b1;
            end else begin
              state         <= RD;
              ramWE_nR      <= 1'b1;
              ramOE_nR      <= 1'b0;
              ramDataDriveR <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end

        RD: begin
          if (cnt == 4'd0) begin
            if (grantMe) begin
              meReadDataR <= bus.ramDataIn;
              meReadyR    <= 1'b1;
            end else begin
              ifDataR     <= bus.ramDataIn;
              ifReadyR    <= 1'b1;
            end
            ramCE_nR <= 1'b1;
            ramOE_nR <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WR: begin
          if (cnt == 4'd0) begin
            ramWE_nR <= 1'b1;   // end the pulse; address/data held one more cycle
            state    <= WR_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WR_HOLD: begin
          ramCE_nR      <= 1'b1;
          ramDataDriveR <= 1'b0;
          meReadyR      <= grantMe;
          ifReadyR      <= ~grantMe;
          state         <= RESP;
        end

        RESP: begin
          ifReadyR <= 1'b0;
          meReadyR <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          ifReadyR      <= 1'b0;
          meReadyR      <= 1'b0;
          ramCE_nR      <= 1'b1;
          ramOE_nR      <= 1'b1;
          ramWE_nR      <= 1'b1;
          ramDataDriveR <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.ifReady      = ifReadyR;
  assign bus.meReady      = meReadyR;
  assign bus.ifData       = ifDataR;
  assign bus.meReadData   = meReadDataR;
  assign bus.ramAddr      = ramAddrR;
  assign bus.ramDataOut   = ramDataOutR;
  assign bus.ramDataDrive = ramDataDriveR;
  assign bus.ramCE_n      = ramCE_nR;
  assign bus.ramOE_n      = ramOE_nR;
  assign bus.ramWE_n      = ramWE_nR;

  // Stalls drop in the same cycle as the matching ready pulse
  assign bus.ifStall = bus.ifReq & ~ifReadyR;
  assign bus.meStall = meActive & ~meReadyR;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with ACCESS_CYCLES=2.
// A small SRAM lookup returns fixed words for known addresses. Inputs
// change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents seen on the data-in bus
  always_comb begin
    case (bus.ramAddr)
      16'h0010: bus.ramDataIn = 16'h1234;
      16'h0020: bus.ramDataIn = 16'h5678;
      16'h0300: bus.ramDataIn = 16'hCAFE;
      default:  bus.ramDataIn = 16'hDEAD;
    endcase
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.ramDataDrive, bus.ifReady, bus.meReady} !== 6'b111000) begin
      failures++;
      $display("FAIL reset_ctrl got %b expected %b",
               {bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.ramDataDrive, bus.ifReady, bus.meReady}, 6'b111000);
    end
    checks++;
    if ({bus.ifData, bus.meReadData, bus.ramAddr} !== 48'h0) begin
      failures++;
      $display("FAIL reset_data got %h expected 0", {bus.ifData, bus.meReadData, bus.ramAddr});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    // {CE_n, OE_n, WE_n, drive, ifReady, ifStall}: IDLE, RD, RD, RESP
    logic [5:0] expv [4];
    expv = '{6'b111001, 6'b001001, 6'b001001, 6'b111010};
    bus.ifReq  = 1'b1;
    bus.ifAddr = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.ramDataDrive, bus.ifReady, bus.ifStall} !== expv[k]) begin
        failures++;
        $display("FAIL if_read_ctrl cycle %0d got %b expected %b", k + 1,
                 {bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.ramDataDrive, bus.ifReady, bus.ifStall}, expv[k]);
      end
      if (k == 1 || k == 2) begin
        checks++;
        if (bus.ramAddr !== 16'h0010) begin
          failures++;
          $display("FAIL if_read_addr cycle %0d got %h expected 0010", k + 1, bus.ramAddr);
        end
      end
      if (k == 3) begin
        checks++;
        if (bus.ifData !== 16'h1234) begin
          failures++;
          $display("FAIL if_read_data got %h expected 1234", bus.ifData);
        end
      end
      @(posedge clk); #1;
    end
    bus.ifReq = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ifReady, bus.ifStall, bus.ifData} !== {2'b00, 16'h1234}) begin
      failures++;
      $display("FAIL if_read_after got %b/%b/%h expected 0/0/1234", bus.ifReady, bus.ifStall, bus.ifData);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_me_write();
    // {CE_n, OE_n, WE_n, drive, meReady, meStall}: IDLE, WR, WR, WR_HOLD, RESP
    logic [5:0] expv [5];
    expv = '{6'b111001, 6'b010101, 6'b010101, 6'b011101, 6'b111010};
    bus.meMemControl = 2'b01;
    bus.meAddr       = 16'h0200;
    bus.meWriteData  = 16'hBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.ramDataDrive, bus.meReady, bus.meStall} !== expv[k]) begin
        failures++;
        $display("FAIL me_write_ctrl cycle %0d got %b expected %b", k + 1,
                 {bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.ramDataDrive, bus.meReady, bus.meStall}, expv[k]);
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if ({bus.ramAddr, bus.ramDataOut} !== {16'h0200, 16'hBEEF}) begin
          failures++;
          $display("FAIL me_write_bus cycle %0d got %h/%h expected 0200/beef", k + 1, bus.ramAddr, bus.ramDataOut);
        end
      end
      @(posedge clk); #1;
    end
    bus.meMemControl = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.meReady, bus.meStall, bus.ramCE_n, bus.ifData} !== {3'b001, 16'h1234}) begin
      failures++;
      $display("FAIL me_write_after got %b%b%b/%h expected 001/1234", bus.meReady, bus.meStall, bus.ramCE_n, bus.ifData);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    // {ifReady, meReady, ifStall, meStall, OE_n} for 12 cycles:
    // ME read (1-4), IF read while ME re-requests (5-8), ME read again (9-12)
    logic [4:0]  expv [12];
    logic [15:0] expAddr [12];
    expv    = '{5'b00111, 5'b00110, 5'b00110, 5'b01101,
                5'b00111, 5'b00110, 5'b00110, 5'b10011,
                5'b00011, 5'b00010, 5'b00010, 5'b01001};
    expAddr = '{16'h0, 16'h0300, 16'h0300, 16'h0,
                16'h0, 16'h0020, 16'h0020, 16'h0,
                16'h0, 16'h0010, 16'h0010, 16'h0};
    rst = 1'b1;
    @(posedge clk); #1;
    bus.ifReq        = 1'b1;
    bus.ifAddr       = 16'h0020;
    bus.meMemControl = 2'b10;
    bus.meAddr       = 16'h0300;
    rst              = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ifReady, bus.meReady, bus.ifStall, bus.meStall, bus.ramOE_n} !== expv[k]) begin
        failures++;
        $display("FAIL contention_ctrl cycle %0d got %b expected %b", k + 1,
                 {bus.ifReady, bus.meReady, bus.ifStall, bus.meStall, bus.ramOE_n}, expv[k]);
      end
      if (expv[k][0] == 1'b0) begin
        checks++;
        if (bus.ramAddr !== expAddr[k]) begin
          failures++;
          $display("FAIL contention_addr cycle %0d got %h expected %h", k + 1, bus.ramAddr, expAddr[k]);
        end
      end
      if (k == 3) begin
        checks++;
        if ({bus.meReadData, bus.ifData} !== {16'hCAFE, 16'h0000}) begin
          failures++;
          $display("FAIL contention_me_data got %h/%h expected cafe/0000", bus.meReadData, bus.ifData);
        end
      end
      if (k == 7) begin
        checks++;
        if (bus.ifData !== 16'h5678) begin
          failures++;
          $display("FAIL contention_if_data got %h expected 5678", bus.ifData);
        end
      end
      if (k == 11) begin
        checks++;
        if (bus.meReadData !== 16'h1234) begin
          failures++;
          $display("FAIL contention_me_data2 got %h expected 1234", bus.meReadData);
        end
      end
      @(posedge clk); #1;
      if (k == 3)  bus.meAddr = 16'h0010;
      if (k == 7)  bus.ifReq = 1'b0;
      if (k == 11) bus.meMemControl = 2'b00;
    end
  endtask

  task automatic test_mid_reset();
    bus.ifReq  = 1'b1;
    bus.ifAddr = 16'h0020;
    @(negedge clk);             // IDLE
    @(negedge clk);             // first RD
    @(negedge clk);             // second RD
    checks++;
    if ({bus.ramCE_n, bus.ramOE_n} !== 2'b00) begin
      failures++;
      $display("FAIL midrst_pre got %b expected 00", {bus.ramCE_n, bus.ramOE_n});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.ramDataDrive, bus.ifReady, bus.meReady} !== 6'b111000) begin
      failures++;
      $display("FAIL midrst_async got %b expected 111000",
               {bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.ramDataDrive, bus.ifReady, bus.meReady});
    end
    checks++;
    if ({bus.ifData, bus.meReadData, bus.ramAddr} !== 48'h0) begin
      failures++;
      $display("FAIL midrst_data got %h expected 0", {bus.ifData, bus.meReadData, bus.ramAddr});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ifReady, bus.ifStall} !== ((k == 3) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL midrst_regrant cycle %0d got %b expected %b", k + 1,
                 {bus.ifReady, bus.ifStall}, ((k == 3) ? 2'b10 : 2'b01));
      end
      if (k == 3) begin
        checks++;
        if (bus.ifData !== 16'h5678) begin
          failures++;
          $display("FAIL midrst_data_after got %h expected 5678", bus.ifData);
        end
      end
      @(posedge clk); #1;
    end
    bus.ifReq = 1'b0;
  endtask

  task automatic test_reserved();
    bus.meMemControl = 2'b11;
    bus.meAddr       = 16'h0300;
    bus.ifReq        = 1'b1;
    bus.ifAddr       = 16'h0010;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.meReady, bus.meStall} !== 2'b00) begin
        failures++;
        $display("FAIL reserved_me cycle %0d got %b expected 00", k + 1, {bus.meReady, bus.meStall});
      end
      if (k == 1 || k == 2) begin
        checks++;
        if ({bus.ramOE_n, bus.ramAddr} !== {1'b0, 16'h0010}) begin
          failures++;
          $display("FAIL reserved_addr cycle %0d got %b/%h expected 0/0010", k + 1, bus.ramOE_n, bus.ramAddr);
        end
      end
      if (k == 3) begin
        checks++;
        if ({bus.ifReady, bus.ifData} !== {1'b1, 16'h1234}) begin
          failures++;
          $display("FAIL reserved_if got %b/%h expected 1/1234", bus.ifReady, bus.ifData);
        end
      end
      if (k >= 4) begin
        checks++;
        if (bus.ramCE_n !== 1'b1) begin
          failures++;
          $display("FAIL reserved_nogrant cycle %0d got CE_n=%b expected 1", k + 1, bus.ramCE_n);
        end
      end
      @(posedge clk); #1;
      if (k == 3) bus.ifReq = 1'b0;
    end
    bus.meMemControl = 2'b00;
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    bus.ifReq        = 1'b0;
    bus.ifAddr       = 16'h0000;
    bus.meMemControl = 2'b00;
    bus.meAddr       = 16'h0000;
    bus.meWriteData  = 16'h0000;
    test_reset();
    test_if_read();
    test_me_write();
    test_contention();
    test_mid_reset();
    test_reserved();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
